// File: rtl/dsm_pkg.sv
// dsm_pkg: shared types and default parameters for the delta-sigma DAC chain
package dsm_pkg;
    localparam int DSM_WIDTH    = 16;
    localparam int DSM_OSR_LOG2 = 6;
    localparam int DSM_CLK_DIV  = 4;
    typedef logic signed [DSM_WIDTH-1:0] sample_t;
    typedef enum logic {FS_IDLE, FS_RUN} feeder_state_t;
endpackage

// File: rtl/dsm_tick_gen.sv
// dsm_tick_gen: free-running CLK_DIV divider producing a registered one-cycle modulator tick
module dsm_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic clk_en
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            clk_en <= 1'b0;
        end else begin
            cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
            clk_en <= (cnt == LAST);
        end
    end
endmodule

// File: rtl/dsm_interp_feeder.sv
// dsm_interp_feeder: buffers PCM samples and linearly interpolates them onto the modulator tick grid
module dsm_interp_feeder
    import dsm_pkg::*;
#(
    parameter int WIDTH    = DSM_WIDTH,
    parameter int OSR_LOG2 = DSM_OSR_LOG2,
    parameter int CLK_DIV  = DSM_CLK_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic signed [WIDTH-1:0] dsm_in,
    output logic                    clk_en,
    output logic                    underrun,
    input  logic                    underrun_clr
);
    localparam int ACC_W = WIDTH + OSR_LOG2;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]              state;
    logic signed [WIDTH-1:0] buf_q;
    logic signed [WIDTH-1:0] tgt;
    logic                    buf_full;
    logic signed [WIDTH:0]   delta;
    logic signed [WIDTH:0]   diff;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] tgt_ext;
    logic [OSR_LOG2-1:0]     phase;
    logic                    hs;
    logic                    load;
    logic                    und_set;

    dsm_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en)
    );

    assign s_ready = ~buf_full;
    assign hs      = s_valid & s_ready;
    // phase stays 0 in IDLE, so phase==0 marks a boundary in both states
    assign load    = clk_en & buf_full & (phase == '0);
    assign und_set = clk_en & ~buf_full & (state == RUN) & (phase == '0);
    assign diff    = (WIDTH+1)'(buf_q) - (WIDTH+1)'(tgt);
    assign tgt_ext = {tgt, {OSR_LOG2{1'b0}}};
    assign dsm_in  = acc[ACC_W-1:OSR_LOG2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            buf_q    <= '0;
            buf_full <= 1'b0;
            tgt      <= '0;
            delta    <= '0;
            acc      <= '0;
            phase    <= '0;
            underrun <= 1'b0;
        end else begin
            if (hs)
                buf_q <= s_data;
            buf_full <= hs | (buf_full & ~load);
            underrun <= und_set | (underrun & ~underrun_clr);
            if (clk_en && (state == RUN || load)) begin
                phase <= phase + 1'b1;
                if (load) begin
                    state <= RUN;
                    delta <= diff;
                    tgt   <= buf_q;
                    acc   <= tgt_ext + ACC_W'(diff);
                end else if (phase == '0) begin
                    delta <= '0;
                    acc   <= tgt_ext;
                end else begin
                    acc <= acc + ACC_W'(delta);
                end
            end
        end
    end
endmodule

// File: tb/tb_dsm_interp_feeder.sv
// tb_dsm_interp_feeder: directed vector table plus randomized traffic against a segment-level model
module tb_dsm_interp_feeder;
    localparam int W = 16;
    localparam int L = 2;
    localparam int D = 3;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s_valid = 1'b0;
    logic underrun_clr = 1'b0;
    logic signed [W-1:0] s_data = '0;
    logic s_ready, clk_en, underrun;
    logic signed [W-1:0] dsm_in;

    int n_checks = 0;
    int n_fail = 0;

    int m_buf, m_tgt, m_s, m_e, m_k, m_out, m_cnt;
    bit m_full, m_run, m_und, m_clk_en;

    typedef struct {
        bit               push;
        logic [W-1:0]     data;
        logic [3:0][W-1:0] exp;
        bit               und;
    } vec_t;
    vec_t vt[3];

    dsm_interp_feeder #(.WIDTH(W), .OSR_LOG2(L), .CLK_DIV(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .dsm_in       (dsm_in),
        .clk_en       (clk_en),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    function automatic int fdiv(input int a, input int n);
        return (a >= 0) ? a / n : -((-a + n - 1) / n);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic model_reset();
        m_buf = 0; m_tgt = 0; m_s = 0; m_e = 0; m_k = 0; m_out = 0; m_cnt = 0;
        m_full = 0; m_run = 0; m_und = 0; m_clk_en = 0;
    endtask

    // One posedge of the spec: ticks walk a segment from start to end point in N equal steps
    task automatic model_step();
        bit tick, full0, set;
        if (!rst) begin
            model_reset();
        end else begin
            tick = m_clk_en;
            full0 = m_full;
            set = 0;
            if (tick && (m_run ? (m_k == N - 1) : full0)) begin
                m_s = m_tgt;
                if (full0) begin
                    m_e = m_buf;
                    m_tgt = m_buf;
                    m_full = 0;
                end else begin
                    m_e = m_tgt;
                    set = 1;
                end
                m_run = 1;
                m_k = 0;
            end else if (tick && m_run) begin
                m_k++;
            end
            if (tick && m_run)
                m_out = m_s + fdiv((m_k + 1) * (m_e - m_s), N);
            if (s_valid && !full0) begin
                m_buf = int'(s_data);
                m_full = 1;
            end
            m_und = set || (m_und && !underrun_clr);
            m_cnt++;
            m_clk_en = (m_cnt % D == 0);
        end
    endtask

    task automatic check_all();
        chk("dsm_in", int'(dsm_in), m_out);
        chk("s_ready", int'(s_ready), int'(!m_full));
        chk("clk_en", int'(clk_en), int'(m_clk_en));
        chk("underrun", int'(underrun), int'(m_und));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_tick();
        bit t;
        for (int i = 0; i < 10; i++) begin
            t = clk_en;
            cycle();
            if (t) return;
        end
        chk("tick_timeout", 0, 1);
    endtask

    task automatic push(input logic [W-1:0] d);
        bit done;
        done = 0;
        s_valid = 1'b1;
        s_data = d;
        for (int i = 0; i < 20 && !done; i++) begin
            done = s_ready;
            cycle();
        end
        s_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    initial begin
        int first;
        int hs_cnt;
        bit t;
        logic [W-1:0] d;
        vt[0] = '{push: 1'b1, data: 16'h0400, exp: {16'h0400, 16'h0300, 16'h0200, 16'h0100}, und: 1'b0};
        vt[1] = '{push: 1'b1, data: 16'hFC00, exp: {16'hFC00, 16'hFE00, 16'h0000, 16'h0200}, und: 1'b0};
        vt[2] = '{push: 1'b0, data: 16'h0000, exp: {16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00}, und: 1'b1};
        model_reset();

        repeat (5) cycle();
        chk("rst_dsm_in", int'(dsm_in), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_underrun", int'(underrun), 0);
        rst = 1'b1;
        first = -1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            if (clk_en && first < 0) first = i;
        end
        chk("first_tick", first, 3);

        foreach (vt[r]) begin
            if (vt[r].push) push(vt[r].data);
            for (int i = 0; i < N; i++) begin
                wait_tick();
                chk($sformatf("vec%0d_dsm_in%0d", r, i), int'(dsm_in), int'($signed(vt[r].exp[i])));
                chk($sformatf("vec%0d_underrun%0d", r, i), int'(underrun), int'(vt[r].und));
            end
        end
        underrun_clr = 1'b1;
        cycle();
        underrun_clr = 1'b0;
        chk("underrun_clr", int'(underrun), 0);

        // continuous valid: the single buffer should admit exactly one sample per segment
        d = 16'h0100;
        s_valid = 1'b1;
        s_data = d;
        hs_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            t = s_ready;
            cycle();
            if (t) begin
                if (i >= 24) hs_cnt++;
                d = d + 16'h0111;
                s_data = d;
            end
        end
        s_valid = 1'b0;
        chk("bp_rate", hs_cnt, 8);
        chk("bp_underrun", int'(underrun), 0);

        for (int i = 0; i < 1500; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data = W'($urandom_range(0, 65535));
            underrun_clr = ($urandom_range(0, 15) == 0);
            cycle();
        end
        s_valid = 1'b0;
        underrun_clr = 1'b0;

        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        push(16'h7FFF);
        wait_tick();
        wait_tick();
        chk("ramp_7fff_phase2", int'(dsm_in), 16'h3FFF);
        push(16'h1234);
        rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_dsm_in", int'(dsm_in), 0);
        chk("mid_rst_s_ready", int'(s_ready), 1);
        chk("mid_rst_underrun", int'(underrun), 0);
        chk("mid_rst_clk_en", int'(clk_en), 0);
        repeat (3) cycle();
        rst = 1'b1;
        repeat (30) cycle();
        chk("post_rst_dsm_in", int'(dsm_in), 0);
        chk("post_rst_underrun", int'(underrun), 0);
        chk("post_rst_s_ready", int'(s_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dsm_interp_feeder.md
# dsm_interp_feeder

Upstream feeder for the second-order delta-sigma DAC. It accepts PCM samples at the audio rate over a valid/ready handshake and generates the DAC's `clk_en` modulator tick. On every tick it drives `dsm_in` with a linearly interpolated value between consecutive samples, so the modulator sees a smooth ramp instead of a zero-order-hold staircase. It also holds the output on input underrun and reports the underrun.

## Interface
- `WIDTH`, 16: sample width, two's complement; same as DAC `WIDTH`.
- `OSR_LOG2`, 6: log2 of modulator ticks per input sample (segment length N = 2**OSR_LOG2).
- `CLK_DIV`, 4: system clocks per modulator tick; must be ≥ 2.
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-low reset.
- `s_data` in WIDTH: input sample, signed.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: block can accept a sample.
- `dsm_in` out WIDTH: interpolated sample to DAC, signed.
- `clk_en` out 1: one-cycle modulator tick to DAC.
- `underrun` out 1: sticky underrun flag.
- `underrun_clr` in 1: clears `underrun`.

## Operation
- **Tick generator.** A counter runs 0..CLK_DIV-1 and wraps. `clk_en` is registered and high for exactly one cycle when the counter equals CLK_DIV-1. It runs freely from reset release, whatever the state.
- **Input buffer.** One entry, `buf`, with flag `buf_full`.
  - `s_ready = ~buf_full`.
  - A handshake (`s_valid & s_ready`) loads `buf` and sets `buf_full`.
- **Datapath registers:**
  - `tgt`: current segment end point, WIDTH bits.
  - `delta`: per-tick step, signed WIDTH+1.
  - `acc`: signed WIDTH+OSR_LOG2.
  - `phase`: OSR_LOG2 bits.
  - `dsm_in = acc[WIDTH+OSR_LOG2-1:OSR_LOG2]`, an arithmetic floor.
- **FSM states:**
  - IDLE, entered from reset:
    - `phase` is held at 0 and `underrun` is never set.
    - On the first tick with `buf_full`, perform a boundary load and go to RUN.
  - RUN:
    - Each tick with `phase==0` is a boundary.
    - All other ticks: `acc += sext(delta)`.
    - `phase` increments every tick and wraps at N.
- **Boundary load** (with `T` = old `tgt`):
  - If `buf_full`:
    - `delta = buf - T` (WIDTH+1 bits, no overflow).
    - `tgt = buf`.
    - `acc = (T << OSR_LOG2) + sext(delta)`.
    - Clear `buf_full`.
  - Else (RUN only):
    - `delta = 0`.
    - `acc = T << OSR_LOG2`.
    - Set `underrun`.
    - Stay in RUN; output holds at `T`.
- **Arithmetic guarantees.** After N ticks of a segment, `acc == tgt << OSR_LOG2` exactly. Intermediate values lie between the endpoints, so `acc` never overflows.
- **Simultaneous events:**
  - A handshake and a boundary on the same cycle with the buffer empty: the sample goes into `buf` and the boundary takes the underrun path. The sample is used at the next boundary.
  - `underrun_clr` and a set condition on the same cycle: set wins.

## Timing
- Reset values:
  - `dsm_in` = 0, `clk_en` = 0, `s_ready` = 1, `underrun` = 0.
  - `acc`, `tgt`, `delta`, `phase` and both counters are 0; `buf_full` = 0; state IDLE.
- The first `clk_en` pulse occurs CLK_DIV cycles after reset deassertion.
- `dsm_in` updates on the clock edge where `clk_en` is high. The DAC samples the pre-update value at that edge; the new value is stable for the next CLK_DIV cycles.
- `s_ready` is a register-derived combinational output. It drops in the cycle after an accepted handshake and rises in the cycle after the boundary that consumes `buf`.
- Latency: an accepted sample reaches `dsm_in` in full N ticks after the boundary that consumes it.
- Reset asserted mid-operation clears everything asynchronously. The buffered sample is discarded.

## Structure
- Shared package `dsm_pkg`:
  - `typedef` `sample_t` (signed WIDTH) and `feeder_state_t` (IDLE, RUN).
  - Default constants `DSM_WIDTH=16`, `DSM_OSR_LOG2=6`, `DSM_CLK_DIV=4`.
- Sub-module `dsm_tick_gen`: a parameterised CLK_DIV counter producing registered `clk_en`. It is reusable by other DSM stages.
- The top level holds the buffer, FSM and interpolator.

## Test plan
All scenarios use WIDTH=16, OSR_LOG2=2, CLK_DIV=3.
- **Reset.** Hold `rst` low 5 cycles, then release.
  - `dsm_in`=0, `s_ready`=1, `underrun`=0.
  - `clk_en` pulses every 3 cycles, first pulse 3 cycles after release.
- **First-sample ramp.** Push 0x0400 in IDLE.
  - Next 4 ticks: `dsm_in` = 0x0100, 0x0200, 0x0300, 0x0400.
- **Negative ramp.** Then push 0xFC00.
  - Next segment: `dsm_in` = 0x0200, 0x0000, 0xFE00, 0xFC00.
- **Underrun.** No sample available at a boundary after the previous scenario.
  - `dsm_in` holds 0xFC00 for 4 ticks and `underrun`=1.
  - Pulse `underrun_clr`: `underrun`=0.
- **Backpressure.** Hold `s_valid` high continuously with an incrementing pattern.
  - `s_ready` is low while `buf_full`.
  - Exactly one sample is accepted per 4 ticks; none dropped or duplicated.
  - End points match the inputs exactly.
- **Reset mid-segment.** Assert `rst` at `phase`=2 of a ramp to 0x7FFF.
  - All outputs are at reset values immediately.
  - After release the block returns to IDLE; no `underrun`.
